// File: rtl/fir_out_requant.sv
// fir_out_requant
//   Sink-side requantizer for the FIR filter output stream. Takes the full-width
//   (DATA_W+GAIN_W) filter sample, rounds/truncates and arithmetic-shifts it,
//   saturates to DATA_W and queues the result in a show-ahead FIFO drained by a
//   valid/ready consumer. Reports FIFO overflow (sticky) and counts clipped samples.
//
//   Build option: define FIR_REQUANT_ROUND_EN for round-half-up before the shift;
//   otherwise the shift truncates (floor toward -inf). Latency is 3 clocks either way.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   valid_in   in   data_in carries a valid sample this cycle
//   data_in    in   signed filter output sample, IN_W bits
//   out_ready  in   downstream accepts data_out this cycle
//   clr_ovf    in   synchronous clear of the overflow flag
//   valid_out  out  FIFO non-empty, data_out valid
//   data_out   out  signed requantized sample at FIFO head, DATA_W bits
//   level      out  FIFO occupancy 0..DEPTH
//   overflow   out  sticky: a sample was dropped on a full FIFO
//   sat_cnt    out  saturating count of clipped samples

module fir_out_requant #(
  parameter int DATA_W = 16,
  parameter int GAIN_W = 4,
  parameter int SHIFT  = 2,
  parameter int DEPTH  = 8,
  localparam int IN_W  = DATA_W + GAIN_W,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [IN_W-1:0]   data_in,
  input  logic              out_ready,
  input  logic              clr_ovf,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic [LVL_W-1:0]  level,
  output logic              overflow,
  output logic [15:0]       sat_cnt
);

  localparam int PTR_W  = $clog2(DEPTH);
  // One extra bit so the rounding add can never wrap.
  localparam int RW     = IN_W + 1;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

`ifdef FIR_REQUANT_ROUND_EN
  localparam logic [RW-1:0] RND = (SHIFT > 0) ? (RW'(1) << RND_SH) : '0;
`else
  localparam logic [RW-1:0] RND = '0;
`endif

  localparam logic signed [RW-1:0] SAT_MAX = {{(RW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = {{(RW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0]    OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]    OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  logic                 s1_vld_q, s1_vld_d;
  logic signed [RW-1:0] s1_q, s1_d;
  logic                 s2_vld_q, s2_vld_d;
  logic [DATA_W-1:0]    s2_q, s2_d;
  logic [15:0]          sat_cnt_q, sat_cnt_d;

  // ---------------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              overflow_q, overflow_d;
  // Last popped value; presented while empty so data_out holds.
  logic [DATA_W-1:0] hold_q, hold_d;

  logic signed [RW-1:0] r_sum;
  logic                 clip;
  logic                 full;
  logic                 pop;
  logic                 wr_en;
  logic                 drop;

  // Stage 1: round-add on the widened sample, then arithmetic shift.
  always_comb begin
    r_sum    = $signed({data_in[IN_W-1], data_in}) + $signed(RND);
    s1_d     = r_sum >>> SHIFT;
    s1_vld_d = valid_in;
  end

  // Stage 2: clip to the DATA_W signed range and count clipped samples.
  always_comb begin
    clip     = 1'b0;
    s2_d     = s1_q[DATA_W-1:0];
    s2_vld_d = s1_vld_q;
    if (s1_q > SAT_MAX) begin
      clip = 1'b1;
      s2_d = OUT_MAX;
    end else if (s1_q < SAT_MIN) begin
      clip = 1'b1;
      s2_d = OUT_MIN;
    end
    sat_cnt_d = sat_cnt_q;
    if (s1_vld_q && clip && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  // Stage 3: FIFO write/pop bookkeeping. A full FIFO still accepts a write
  // when the head is popped in the same cycle.
  always_comb begin
    full  = (level_q == LVL_W'(DEPTH));
    pop   = (level_q != '0) && out_ready;
    wr_en = s2_vld_q && (!full || pop);
    drop  = s2_vld_q && full && !pop;

    wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    hold_d   = pop   ? mem_q[rd_ptr_q]      : hold_q;

    level_d = level_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // A drop in the same cycle as a clear keeps the flag set.
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_q       <= '0;
      s2_vld_q   <= 1'b0;
      s2_q       <= '0;
      sat_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_q       <= s1_d;
      s2_vld_q   <= s2_vld_d;
      s2_q       <= s2_d;
      sat_cnt_q  <= sat_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      hold_q     <= hold_d;
    end
  end

  // Storage needs no reset: entries are only visible once written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= s2_q;
    end
  end

  assign valid_out = (level_q != '0);
  assign data_out  = valid_out ? mem_q[rd_ptr_q] : hold_q;
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign sat_cnt   = sat_cnt_q;

endmodule
